// File: rtl/panda_hazard_unit.sv
// panda_hazard_unit: load-use detection, data-memory handshake hold tracker,
// saturating hold-cycle counter and sticky handshake timeout flag.
module panda_hazard_unit #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_read_i,
    input  logic             id_rs2_read_i,
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             mem_req_i,
    input  logic             mem_we_i,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    output logic             load_use_hazard_o,
    output logic             mem_stall_o,
    output logic             dmem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT    = 2'd1;
    localparam logic [1:0] ST_WAIT_RVALID = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              stall_fsm;
    logic              timeout;
    logic              raw_hazard;
    logic              hold;

    // Next-state logic of the memory handshake tracker, including timeout abort
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        stall_fsm  = 1'b0;
        timeout    = (wait_cnt_q == WAIT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    if (dmem_gnt_i) begin
                        if (!mem_we_i) begin
                            stall_fsm  = 1'b1;
                            state_d    = ST_WAIT_RVALID;
                            wait_cnt_d = '0;
                        end
                    end else begin
                        stall_fsm  = 1'b1;
                        state_d    = ST_WAIT_GNT;
                        wait_cnt_d = '0;
                    end
                end
            end
            ST_WAIT_GNT: begin
                if (dmem_gnt_i) begin
                    if (mem_we_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        stall_fsm  = 1'b1;
                        state_d    = ST_WAIT_RVALID;
                        wait_cnt_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    stall_fsm  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_WAIT_RVALID: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    stall_fsm  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Hold outputs: memory stall wins over load-use; both suppressed in reset
    always_comb begin
        raw_hazard = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != 5'd0)
                   & ((id_rs1_read_i & (id_rs1_addr_i == ex_rd_addr_i))
                    | (id_rs2_read_i & (id_rs2_addr_i == ex_rd_addr_i)));
        mem_stall_o       = stall_fsm & ~rst_i;
        load_use_hazard_o = raw_hazard & ~mem_stall_o & ~rst_i;
        hold              = load_use_hazard_o | mem_stall_o;
        stall_cnt_d       = stall_cnt_q;
        if (hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait timer, error flag and hold counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem_err_o  = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_panda_hazard_unit.sv
// Bench for panda_hazard_unit: vector table, directed handshake sequences and
// randomized traffic against a transaction-level reference model.
module tb_panda_hazard_unit;

    localparam int unsigned MAX_WAIT = 16;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs1, rs2;
    logic        rs1_rd, rs2_rd;
    logic        ex_valid, ex_load;
    logic [4:0]  rd;
    logic        req, we, gnt, rvalid;
    logic        haz, stall, err;
    logic [31:0] cnt;
    logic        haz_s, stall_s, err_s;
    logic [1:0]  cnt_s;

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding access at most, described by whether
    // it exists, whether it was granted, and how many wait cycles it has used.
    bit      m_busy;
    bit      m_granted;
    int      m_age;
    bit      m_err;
    longint  m_cnt;
    int      m_cnt2;

    panda_hazard_unit #(.CNT_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_read_i(rs1_rd), .id_rs2_read_i(rs2_rd),
        .ex_valid_i(ex_valid), .ex_mem_read_i(ex_load), .ex_rd_addr_i(rd),
        .mem_req_i(req), .mem_we_i(we), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .load_use_hazard_o(haz), .mem_stall_o(stall), .dmem_err_o(err), .stall_cnt_o(cnt)
    );

    panda_hazard_unit #(.CNT_W(2), .MAX_WAIT(MAX_WAIT)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_read_i(rs1_rd), .id_rs2_read_i(rs2_rd),
        .ex_valid_i(ex_valid), .ex_mem_read_i(ex_load), .ex_rd_addr_i(rd),
        .mem_req_i(req), .mem_we_i(we), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .load_use_hazard_o(haz_s), .mem_stall_o(stall_s), .dmem_err_o(err_s), .stall_cnt_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_raw();
        return id_valid && ex_valid && ex_load && (rd != 0) &&
               ((rs1_rd && rs1 == rd) || (rs2_rd && rs2 == rd));
    endfunction

    // Whether the outstanding access (or a new one) keeps the pipeline frozen now
    function automatic bit exp_stall();
        bit expired;
        expired = (m_age == MAX_WAIT - 1);
        if (rst) return 1'b0;
        if (!m_busy) return req && !(gnt && we);
        if (!m_granted) return gnt ? !we : !expired;
        return !rvalid && !expired;
    endfunction

    function automatic bit exp_haz();
        return !rst && exp_raw() && !exp_stall();
    endfunction

    task automatic model_check();
        check("mem_stall", longint'(stall), longint'(exp_stall()));
        check("hazard", longint'(haz), longint'(exp_haz()));
        check("err", longint'(err), longint'(m_err));
        check("stall_cnt", longint'(cnt), m_cnt);
        check("stall_cnt_w2", longint'(cnt_s), longint'(m_cnt2));
        check("err_w2", longint'(err_s), longint'(m_err));
    endtask

    task automatic model_update();
        bit s, h, expired;
        s = exp_stall();
        h = exp_haz();
        expired = (m_age == MAX_WAIT - 1);
        if (rst) begin
            m_busy = 0; m_granted = 0; m_age = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        if (s || h) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (!m_busy) begin
            if (req && !(gnt && we)) begin
                m_busy = 1; m_granted = gnt; m_age = 0;
            end
        end else if (!m_granted) begin
            if (gnt) begin
                if (we) m_busy = 0;
                else begin m_granted = 1; m_age = 0; end
            end else if (expired) begin
                m_busy = 0; m_err = 1;
            end else m_age++;
        end else begin
            if (rvalid) m_busy = 0;
            else if (expired) begin m_busy = 0; m_err = 1; end
            else m_age++;
        end
    endtask

    // One clock: compare mid-cycle, then advance the model at the edge
    task automatic cyc();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; rs1 = 0; rs2 = 0; rs1_rd = 0; rs2_rd = 0;
        ex_valid = 0; ex_load = 0; rd = 0;
        req = 0; we = 0; gnt = 0; rvalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        // Raw hazard present during reset must still be masked
        id_valid = 1; rs1 = 5; rs1_rd = 1; ex_valid = 1; ex_load = 1; rd = 5;
        req = 1; gnt = 0;
        cyc();
        #1;
        check("rst_hazard", longint'(haz), 0);
        check("rst_stall", longint'(stall), 0);
        cyc();
        clear_inputs();
        rst = 0;
        #1;
        check("post_rst_cnt", longint'(cnt), 0);
        check("post_rst_err", longint'(err), 0);
    endtask

    typedef struct {
        logic       idv;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       r1;
        logic       r2;
        logic       exv;
        logic       exl;
        logic [4:0] d;
        logic       h;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        bit prev_stall;
        bit dead;

        vecs[0] = '{1'b1, 5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1};
        vecs[1] = '{1'b1, 5'd0,  5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1};
        vecs[2] = '{1'b1, 5'd0,  5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0};
        vecs[3] = '{1'b1, 5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0};
        vecs[4] = '{1'b0, 5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0};
        vecs[5] = '{1'b1, 5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0};
        vecs[6] = '{1'b1, 5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0};
        vecs[7] = '{1'b1, 5'd31, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 1'b1};
        vecs[8] = '{1'b1, 5'd3,  5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0};
        vecs[9] = '{1'b1, 5'd6,  5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6,  1'b1};

        m_busy = 0; m_granted = 0; m_age = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
        clear_inputs();
        rst = 1;
        @(posedge clk);
        model_update();
        #1;
        do_reset();

        // Load-use table with the memory side idle
        for (int i = 0; i < 10; i++) begin
            id_valid = vecs[i].idv; rs1 = vecs[i].s1; rs2 = vecs[i].s2;
            rs1_rd = vecs[i].r1; rs2_rd = vecs[i].r2;
            ex_valid = vecs[i].exv; ex_load = vecs[i].exl; rd = vecs[i].d;
            #1;
            check($sformatf("vec%0d_hazard", i), longint'(haz), longint'(vecs[i].h));
            cyc();
        end

        // Load granted at once, data three cycles later
        do_reset();
        req = 1; we = 0; gnt = 1;
        #1; check("ld_c0_stall", longint'(stall), 1);
        cyc();
        gnt = 0;
        #1; check("ld_c1_stall", longint'(stall), 1);
        cyc();
        #1; check("ld_c2_stall", longint'(stall), 1);
        cyc();
        rvalid = 1; req = 0;
        #1; check("ld_c3_stall", longint'(stall), 0);
        cyc();
        rvalid = 0;
        #1; check("ld_cnt", longint'(cnt), 3);
        cyc();

        // Store with grant delayed two cycles, then immediate back-to-back store
        do_reset();
        req = 1; we = 1; gnt = 0;
        #1; check("st_c0_stall", longint'(stall), 1);
        cyc();
        #1; check("st_c1_stall", longint'(stall), 1);
        cyc();
        gnt = 1;
        #1; check("st_c2_stall", longint'(stall), 0);
        cyc();
        #1; check("st_b2b_stall", longint'(stall), 0);
        cyc();
        req = 0; gnt = 0;
        #1; check("st_cnt", longint'(cnt), 2);
        cyc();

        // Load whose data never arrives
        do_reset();
        req = 1; we = 0; gnt = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 100; i++) begin
            #1;
            if (stall) n++;
            else break;
            cyc();
            req = 0; gnt = 0;
        end
        check("timeout_stall_cycles", longint'(n), 16);
        check("timeout_release", longint'(stall), 0);
        cyc();
        #1; check("timeout_err", longint'(err), 1);
        for (int i = 0; i < 5; i++) cyc();
        #1; check("timeout_err_sticky", longint'(err), 1);

        // Hazard suppressed by a memory stall; narrow counter saturates
        do_reset();
        id_valid = 1; rs2 = 9; rs2_rd = 1; ex_valid = 1; ex_load = 1; rd = 9;
        req = 1; we = 0; gnt = 0;
        #1;
        check("prio_hazard", longint'(haz), 0);
        check("prio_stall", longint'(stall), 1);
        for (int i = 0; i < 5; i++) cyc();
        #1;
        check("prio_cnt", longint'(cnt), 5);
        check("sat_cnt_w2", longint'(cnt_s), 3);
        rvalid = 1; gnt = 1;
        cyc();
        gnt = 0; req = 0;
        #1;
        check("prio_release_stall", longint'(stall), 0);
        check("prio_release_hazard", longint'(haz), 1);
        cyc();
        clear_inputs();

        // Randomized traffic against the model
        do_reset();
        prev_stall = 0;
        dead = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) dead = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            id_valid = $urandom_range(0, 3) != 0;
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rs1_rd = $urandom_range(0, 1); rs2_rd = $urandom_range(0, 1);
            ex_valid = $urandom_range(0, 3) != 0;
            ex_load = $urandom_range(0, 1);
            rd = 5'($urandom_range(0, 3));
            if (!prev_stall) begin
                req = $urandom_range(0, 2) == 0;
                we = $urandom_range(0, 1);
            end
            gnt = dead ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            rvalid = dead ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            prev_stall = exp_stall();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
